// File: rtl/uart_tx_frame.sv
// -----------------------------------------------------------------------------
// uart_tx_frame
//   UART transmitter with a configurable frame format: start bit, DATA_BITS
//   data bits LSB first, an optional odd/even parity bit and one or two stop
//   bits. The bit period is DIV = FREQ/BAUDRATE clock cycles.
//
//   Build option: define UART_TX_FIFO_EN to put a FIFO_DEPTH-entry FIFO in
//   front of the shifter. In that build, frames queued in the FIFO go out
//   back-to-back.
//
//   Without the option, words are taken straight into the shifter while the
//   FSM is idle. TX_Level then reads 0.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   TX_Valid   producer offers TX_DATA this cycle
//   TX_DATA    word to send, LSB transmitted first
//   TX_Ready   word accepted at the edge where TX_Valid && TX_Ready
//   TX_Serial  registered serial line, idle high
//   TX_BUSY    frame in progress or words still queued
//   TX_Level   FIFO occupancy
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int FREQ       = 100000000,
  parameter int BAUDRATE   = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        TX_Valid,
  input  logic [DATA_BITS-1:0]        TX_DATA,
  output logic                        TX_Ready,
  output logic                        TX_Serial,
  output logic                        TX_BUSY,
  output logic [$clog2(FIFO_DEPTH):0] TX_Level
);

  localparam int DIV   = FREQ / BAUDRATE;
  localparam int CNT_W = $clog2(DIV);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
  localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state_reg, state_next;
  logic [CNT_W-1:0]     baud_reg, baud_next;
  logic [3:0]           bit_reg, bit_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 serial_reg, serial_next;

  logic                 word_avail;  // a word is ready to be loaded now
  logic                 load;        // shifter load (and FIFO pop) this cycle
  logic [DATA_BITS-1:0] load_data;
  logic                 bit_done;    // last cycle of the current bit period

  assign bit_done  = (baud_reg == BAUD_LAST);
  assign TX_Serial = serial_reg;

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  // Words sitting in the FIFO may start the next frame directly from STOP.
  localparam bit CHAIN = 1'b1;

  // Small register file, read asynchronously. This makes the head word
  // available for a load on the cycle after it was pushed.
  logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]     level_reg;
  logic                 push;

  assign TX_Ready   = (level_reg != LVL_W'(FIFO_DEPTH));
  assign push       = TX_Valid && TX_Ready;
  assign word_avail = (level_reg != '0);
  assign load_data  = fifo_mem[rd_ptr_reg];
  assign TX_Level   = level_reg;
  assign TX_BUSY    = (state_reg != S_IDLE) || (level_reg != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_reg] <= TX_DATA;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (load) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      // A simultaneous push and pop leaves the level unchanged.
      case ({push, load})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end
`else
  // With no FIFO, the producer hands over only while idle. This leaves at
  // least one idle cycle between frames.
  localparam bit CHAIN = 1'b0;

  assign TX_Ready   = (state_reg == S_IDLE);
  assign word_avail = TX_Valid;
  assign load_data  = TX_DATA;
  assign TX_Level   = '0;
  assign TX_BUSY    = (state_reg != S_IDLE);
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      serial_reg <= 1'b1;
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      serial_reg <= serial_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    baud_next   = baud_reg;
    bit_next    = bit_reg;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    load        = 1'b0;

    if (state_reg != S_IDLE) begin
      baud_next = bit_done ? '0 : baud_reg + CNT_W'(1);
    end

    case (state_reg)
      S_IDLE: begin
        if (word_avail) begin
          load = 1'b1;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_next = S_DATA;
          bit_next   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_next = S_STOP;
          bit_next   = '0;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (bit_reg == STOP_LAST) begin
            if (CHAIN && word_avail) begin
              load = 1'b1;
            end else begin
              state_next = S_IDLE;
            end
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Every load restarts the baud counter. This makes the start bit exactly
    // DIV cycles long.
    if (load) begin
      state_next  = S_START;
      baud_next   = '0;
      bit_next    = '0;
      shift_next  = load_data;
      parity_next = (PARITY == 1) ? ~(^load_data) : (^load_data);
    end
  end

  // Output logic: the line value is decoded from the next state. The
  // registered TX_Serial therefore changes on the same edge as the state.
  always_comb begin
    case (state_next)
      S_START:  serial_next = 1'b0;
      S_DATA:   serial_next = shift_next[0];
      S_PARITY: serial_next = parity_next;
      default:  serial_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: three instances (8N1, 7E1, 8O2), all with DIV=16.
module tb_uart_tx_frame;

  localparam int DIV = 16;
`ifdef UART_TX_FIFO_EN
  localparam int START_LAT = 2;
`else
  localparam int START_LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       va, vb, vc;
  logic [7:0] da, dc;
  logic [6:0] db;
  logic       ra, rb, rc;
  logic       ser_a, ser_b, ser_c;
  logic       busy_a, busy_b, busy_c;
  logic [2:0] la, lb, lc;

  int         sel;
  logic       mon_line, mon_busy;
  int         n_vec = 0;
  int         n_bad = 0;
  int         frames_done = 0;
  string      sb_q[$];
  int         gap_q[$];

  typedef struct {
    int         sel;
    logic [7:0] data;
    string      exp;
  } vec_t;
  vec_t tv [8];

  int         exp_lvl [6] = '{1, 1, 2, 3, 4, 4};
  int         exp_rdy [6] = '{1, 1, 1, 1, 1, 0};
  logic [7:0] words   [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

  always #5 clk = ~clk;

  uart_tx_frame #(.FREQ(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .TX_Valid(va), .TX_DATA(da), .TX_Ready(ra),
    .TX_Serial(ser_a), .TX_BUSY(busy_a), .TX_Level(la));
  uart_tx_frame #(.FREQ(16), .BAUDRATE(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .TX_Valid(vb), .TX_DATA(db), .TX_Ready(rb),
    .TX_Serial(ser_b), .TX_BUSY(busy_b), .TX_Level(lb));
  uart_tx_frame #(.FREQ(16), .BAUDRATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_c (
    .clk(clk), .reset_n(reset_n), .TX_Valid(vc), .TX_DATA(dc), .TX_Ready(rc),
    .TX_Serial(ser_c), .TX_BUSY(busy_c), .TX_Level(lc));

  assign mon_line = (sel == 0) ? ser_a : (sel == 1) ? ser_b : ser_c;
  assign mon_busy = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expire(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: got timeout, expected completion", name);
  endtask

  function automatic string frame8n1(input logic [7:0] d);
    string s;
    s = "0";
    for (int i = 0; i < 8; i++) s = {s, d[i] ? "1" : "0"};
    return {s, "1"};
  endfunction

  function automatic logic rdy(input int s);
    return (s == 0) ? ra : (s == 1) ? rb : rc;
  endfunction

  task automatic drive(input int s, input logic v, input logic [7:0] d);
    case (s)
      0:       begin va = v; da = d; end
      1:       begin vb = v; db = d[6:0]; end
      default: begin vc = v; dc = d; end
    endcase
  endtask

  task automatic set_vec(input int i, input int s, input logic [7:0] d, input string e);
    tv[i].sel  = s;
    tv[i].data = d;
    tv[i].exp  = e;
  endtask

  // Offer one word and queue its expected frame once the DUT will take it.
  task automatic send(input int s, input logic [7:0] d, input string e);
    int n;
    @(negedge clk);
    drive(s, 1'b1, d);
    n = 0;
    while (rdy(s) !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) expire("send_ready");
    else sb_q.push_back(e);
    @(negedge clk);
    drive(s, 1'b0, d);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n;
    n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frames_done < target) expire("wait_frames");
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (mon_busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (mon_busy !== 1'b0) expire("wait_idle");
  endtask

  // Line monitor: detects each start bit and pops the expected frame. Every
  // cycle of every bit period is checked against it, and the idle cycles
  // before the frame are recorded.
  initial begin : monitor
    string e;
    int    bad, idle, fno;
    bit    prev, abort;
    prev = 1'b1;
    idle = 0;
    fno  = 0;
    forever begin
      @(negedge clk);
      if (reset_n !== 1'b1) begin
        prev = 1'b1;
        idle = 0;
        continue;
      end
      if (prev && mon_line === 1'b0) begin
        gap_q.push_back(idle);
        idle = 0;
        fno++;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_frame %0d: got start bit, expected idle line", fno);
          prev = 1'b0;
        end else begin
          e = sb_q.pop_front();
          abort = 1'b0;
          for (int i = 0; i < e.len() && !abort; i++) begin
            bad = 0;
            for (int c = 0; c < DIV && !abort; c++) begin
              if (!(i == 0 && c == 0)) @(negedge clk);
              if (reset_n !== 1'b1) abort = 1'b1;
              else if (mon_line !== ((e[i] == 8'h31) ? 1'b1 : 1'b0)) bad++;
            end
            if (!abort) check($sformatf("frame%0d_bit%0d_bad_cycles", fno, i), bad, 0);
          end
          if (!abort) begin
            frames_done++;
            prev = mon_line;
          end else begin
            prev = 1'b1;
          end
        end
      end else begin
        if (mon_line === 1'b1) idle++;
        prev = mon_line;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    n_bad++;
    $display("FAIL watchdog: got timeout, expected $finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n, k, j, target;
    set_vec(0, 0, 8'hA5, "0101001011");
    set_vec(1, 0, 8'h00, "0000000001");
    set_vec(2, 0, 8'hFF, "0111111111");
    set_vec(3, 0, 8'h3C, "0001111001");
    set_vec(4, 1, 8'h07, "0111000011");
    set_vec(5, 1, 8'h55, "0101010101");
    set_vec(6, 2, 8'h00, "000000000111");
    set_vec(7, 2, 8'h07, "011100000011");

    reset_n = 1'b0;
    va = 0; vb = 0; vc = 0; da = '0; db = '0; dc = '0;
    sel = 0;
    repeat (3) @(negedge clk);
    check("rst_a_serial", ser_a, 1); check("rst_a_busy", busy_a, 0);
    check("rst_a_ready", ra, 1);     check("rst_a_level", la, 0);
    check("rst_b_serial", ser_b, 1); check("rst_b_busy", busy_b, 0);
    check("rst_b_ready", rb, 1);     check("rst_b_level", lb, 0);
    check("rst_c_serial", ser_c, 1); check("rst_c_busy", busy_c, 0);
    check("rst_c_ready", rc, 1);     check("rst_c_level", lc, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Table-driven frames on all three formats
    for (int i = 0; i < 8; i++) begin
      sel = tv[i].sel;
      target = frames_done + 1;
      send(tv[i].sel, tv[i].data, tv[i].exp);
      wait_frames(target, 400);
      wait_idle(100);
    end

    // Start latency and TX_BUSY fall time (8N1, 0xA5)
    sel = 0;
    target = frames_done + 1;
    @(negedge clk);
    check("lat_ready_idle", ra, 1);
    va = 1'b1; da = 8'hA5;
    sb_q.push_back("0101001011");
    @(negedge clk);
    va = 1'b0;
    k = 1;
    while (ser_a === 1'b1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    check("start_latency", k, START_LAT);
    j = 0;
    while (busy_a !== 1'b0 && j < 400) begin
      @(negedge clk);
      j++;
    end
    check("busy_fall_cycles", j, 160);
    wait_frames(target, 100);

`ifdef UART_TX_FIFO_EN
    // Six pushes on consecutive cycles: the FIFO fills and the sixth is dropped
    gap_q.delete();
    target = frames_done + 5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) check($sformatf("fifo_level_%0d", i), la, exp_lvl[i-1]);
      check($sformatf("fifo_ready_%0d", i), ra, exp_rdy[i]);
      va = 1'b1; da = words[i];
      if (exp_rdy[i] == 1) sb_q.push_back(frame8n1(words[i]));
    end
    @(negedge clk);
    check("fifo_level_6", la, exp_lvl[5]);
    va = 1'b0;
    wait_frames(target, 1200);
    for (int i = 1; i < 5; i++) begin
      if (gap_q.size() > i) check($sformatf("b2b_gap_%0d", i), gap_q[i], 0);
      else expire($sformatf("b2b_gap_%0d", i));
    end
    wait_idle(200);
    check("fifo_drained_level", la, 0);
    check("fifo_drained_ready", ra, 1);
`else
    // Valid held high for two words: one full frame of TX_Ready low, then idle gap
    gap_q.delete();
    target = frames_done + 2;
    @(negedge clk);
    check("nf_ready_idle", ra, 1);
    va = 1'b1; da = 8'h96;
    sb_q.push_back(frame8n1(8'h96));
    @(negedge clk);
    da = 8'h69;
    check("nf_level_tied", la, 0);
    n = 0;
    while (ra !== 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("nf_ready_low_cycles", n, 160);
    sb_q.push_back(frame8n1(8'h69));
    @(negedge clk);
    va = 1'b0;
    wait_frames(target, 600);
    n_vec++;
    if (gap_q.size() < 2 || gap_q[1] < 1) begin
      n_bad++;
      $display("FAIL nf_idle_gap: got %0d idle cycles, expected at least 1",
               (gap_q.size() < 2) ? -1 : gap_q[1]);
    end
    wait_idle(200);
`endif

    // Reset asserted in the middle of the data bits
    sel = 0;
    @(negedge clk);
    va = 1'b1; da = 8'hA5;
    sb_q.push_back("0101001011");
    @(negedge clk);
    va = 1'b0;
    k = 0;
    while (ser_a !== 1'b0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    repeat (40) @(negedge clk);
    check("pre_reset_line", ser_a, 0);
`ifdef UART_TX_FIFO_EN
    va = 1'b1; da = 8'h77;
    @(negedge clk);
    da = 8'h88;
    @(negedge clk);
    va = 1'b0;
    check("pre_reset_level", la, 2);
`endif
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_serial", ser_a, 1);
    check("abort_level", la, 0);
    check("abort_busy", busy_a, 0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    target = frames_done + 1;
    send(0, 8'h3C, "0001111001");
    wait_frames(target, 400);
    wait_idle(100);
    check("post_reset_level", la, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
